regwrite_queue: RTL and testbench

- Write-side initiator for the 32x64 register file: buffers register write-back requests from datapath producers and drives the file's RegWr/RW/BusW write port, one write per granted cycle.
- Provides newest-value forwarding for two read addresses, so readers see queued but uncommitted results.
- XZR (register 31) semantics are enforced at this end: writes to 31 are discarded and never forwarded.

---
 rtl/regwrite_queue.sv | 124 ++++++++++++
 tb/tb_regwrite_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regwrite_queue.sv
// regwrite_queue: write-side initiator for the 32x64 register file.
// Buffers write-back requests in a circular FIFO and drives one register file
// write per granted cycle. Two lookup ports forward the newest queued value so
// readers see results that are queued but not yet committed. Register 31 (XZR)
// is never stored and never forwarded.
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   InValid/InReady       producer handshake; InRW/InData carry the request
//   RfGrant               register file write port free this cycle
//   RegWr/RW/BusW         register file write port (head entry)
//   RA/RB                 forwarding lookup addresses
//   HitA/HitB, FwdA/FwdB  lookup hit flags and newest matching data
//   Count/Empty           occupancy
module regwrite_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [ADDR_W-1:0] InRW,
   input  logic [DATA_W-1:0] InData,
   input  logic              RfGrant,
   output logic              RegWr,
   output logic [ADDR_W-1:0] RW,
   output logic [DATA_W-1:0] BusW,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic              HitA,
   output logic              HitB,
   output logic [DATA_W-1:0] FwdA,
   output logic [DATA_W-1:0] FwdB,
   output logic [ADDR_W-1:0] Count,
   output logic              Empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] XZR = ADDR_W'(31);
   localparam logic [ADDR_W-1:0] DEPTH_CNT = ADDR_W'(DEPTH);

   logic [ADDR_W-1:0] memAddr [DEPTH];
   logic [DATA_W-1:0] memData [DEPTH];

   logic [PTR_W-1:0]  headQ, headD;
   logic [PTR_W-1:0]  tailQ, tailD;
   logic [ADDR_W-1:0] countQ, countD;

   logic accept;
   logic store;
   logic pop;
   logic [PTR_W-1:0] idx;

   assign Empty   = (countQ == '0);
   assign InReady = (countQ < DEPTH_CNT);
   assign Count   = countQ;

   // XZR requests complete the handshake but are dropped here.
   assign accept = InValid & InReady;
   assign store  = accept & (InRW != XZR);
   assign pop    = RfGrant & ~Empty;

   assign RegWr = pop;
   assign RW    = Empty ? '0 : memAddr[headQ];
   assign BusW  = Empty ? '0 : memData[headQ];

   always_comb begin
      headD  = headQ;
      tailD  = tailQ;
      countD = countQ;
      if (pop) begin
         headD = headQ + PTR_W'(1);
      end
      if (store) begin
         tailD = tailQ + PTR_W'(1);
      end
      countD = countQ + ADDR_W'(store) - ADDR_W'(pop);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         headQ  <= '0;
         tailQ  <= '0;
         countQ <= '0;
      end else begin
         headQ  <= headD;
         tailQ  <= tailD;
         countQ <= countD;
      end
   end

   // Entry storage needs no reset: validity comes from head/count.
   always_ff @(posedge Clk) begin
      if (store) begin
         memAddr[tailQ] <= InRW;
         memData[tailQ] <= InData;
      end
   end

   // Walk from oldest to newest so the last match is the newest value.
   always_comb begin
      HitA = 1'b0;
      HitB = 1'b0;
      FwdA = '0;
      FwdB = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = headQ + PTR_W'(k);
         if (ADDR_W'(k) < countQ) begin
            if ((RA != XZR) && (memAddr[idx] == RA)) begin
               HitA = 1'b1;
               FwdA = memData[idx];
            end
            if ((RB != XZR) && (memAddr[idx] == RB)) begin
               HitB = 1'b1;
               FwdB = memData[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_regwrite_queue.sv
// Directed self-checking bench for regwrite_queue (DEPTH=4, DATA_W=64, ADDR_W=5).
module tb_regwrite_queue;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InRW;
   logic [63:0] InData;
   logic        RfGrant;
   logic        RegWr;
   logic [4:0]  RW;
   logic [63:0] BusW;
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic        HitA;
   logic        HitB;
   logic [63:0] FwdA;
   logic [63:0] FwdB;
   logic [4:0]  Count;
   logic        Empty;

   int nCmp = 0;
   int nErr = 0;

   regwrite_queue #(.DEPTH(4), .DATA_W(64), .ADDR_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InRW(InRW),
      .InData(InData), .RfGrant(RfGrant), .RegWr(RegWr), .RW(RW), .BusW(BusW),
      .RA(RA), .RB(RB), .HitA(HitA), .HitB(HitB), .FwdA(FwdA), .FwdB(FwdB),
      .Count(Count), .Empty(Empty)
   );

   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // One accepted request; returns 1 ns after the capturing edge.
   task automatic push(input logic [4:0] a, input logic [63:0] d);
      InValid = 1'b1; InRW = a; InData = d;
      @(posedge Clk); #1;
      InValid = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b1; InValid = 1'b0; InRW = '0; InData = '0; RfGrant = 1'b1;
      RA = 5'd3; RB = 5'd5;
      repeat (2) @(posedge Clk);
      #1;
      nCmp++; if (Count !== 5'd0) begin nErr++; $display("FAIL reset_count got %0d want 0", Count); end
      nCmp++; if (Empty !== 1'b1) begin nErr++; $display("FAIL reset_empty got %b want 1", Empty); end
      nCmp++; if (InReady !== 1'b1) begin nErr++; $display("FAIL reset_inready got %b want 1", InReady); end
      Reset = 1'b0;
      @(posedge Clk); #1;
      nCmp++; if (RegWr !== 1'b0) begin nErr++; $display("FAIL idle_regwr got %b want 0", RegWr); end
      nCmp++; if (RW !== 5'd0 || BusW !== 64'd0) begin nErr++; $display("FAIL idle_port got %0d/%h want 0/0", RW, BusW); end
      nCmp++; if (HitA !== 1'b0 || HitB !== 1'b0) begin nErr++; $display("FAIL idle_hit got %b%b want 00", HitA, HitB); end
      nCmp++; if (Count !== 5'd0 || Empty !== 1'b1) begin nErr++; $display("FAIL idle_count got %0d/%b want 0/1", Count, Empty); end
      RfGrant = 1'b0;
   endtask

   task automatic test_forward;
      push(5'd3, 64'h11);
      nCmp++; if (RW !== 5'd3 || BusW !== 64'h11) begin nErr++; $display("FAIL head_latency got %0d/%h want 3/11", RW, BusW); end
      push(5'd5, 64'h22);
      push(5'd3, 64'h33);
      RA = 5'd3; RB = 5'd5; #1;
      nCmp++; if (Count !== 5'd3) begin nErr++; $display("FAIL fwd_count got %0d want 3", Count); end
      nCmp++; if (HitA !== 1'b1 || FwdA !== 64'h33) begin nErr++; $display("FAIL fwd_a got %b/%h want 1/33", HitA, FwdA); end
      nCmp++; if (HitB !== 1'b1 || FwdB !== 64'h22) begin nErr++; $display("FAIL fwd_b got %b/%h want 1/22", HitB, FwdB); end
      nCmp++; if (RegWr !== 1'b0) begin nErr++; $display("FAIL fwd_regwr got %b want 0", RegWr); end
      nCmp++; if (RW !== 5'd3 || BusW !== 64'h11) begin nErr++; $display("FAIL fwd_head got %0d/%h want 3/11", RW, BusW); end
   endtask

   task automatic test_drain;
      logic [4:0]  expA [3];
      logic [63:0] expD [3];
      expA[0] = 5'd3; expD[0] = 64'h11;
      expA[1] = 5'd5; expD[1] = 64'h22;
      expA[2] = 5'd3; expD[2] = 64'h33;
      RfGrant = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         nCmp++; if (RegWr !== 1'b1 || RW !== expA[i] || BusW !== expD[i]) begin
            nErr++; $display("FAIL drain_%0d got %b/%0d/%h want 1/%0d/%h", i, RegWr, RW, BusW, expA[i], expD[i]);
         end
         // Newest X3 value stays visible while any X3 entry is queued, including the head being written.
         nCmp++; if (HitA !== 1'b1 || FwdA !== 64'h33) begin nErr++; $display("FAIL drain_hit_%0d got %b/%h want 1/33", i, HitA, FwdA); end
         @(posedge Clk); #1;
      end
      nCmp++; if (Empty !== 1'b1 || RegWr !== 1'b0) begin nErr++; $display("FAIL drain_end got %b/%b want 1/0", Empty, RegWr); end
      nCmp++; if (HitA !== 1'b0 || FwdA !== 64'd0) begin nErr++; $display("FAIL drain_end_hit got %b/%h want 0/0", HitA, FwdA); end
      nCmp++; if (HitB !== 1'b0) begin nErr++; $display("FAIL drain_end_hitb got %b want 0", HitB); end
      RfGrant = 1'b0;
   endtask

   task automatic test_full;
      logic [4:0]  expA [3];
      logic [63:0] expD [3];
      expA[0] = 5'd3; expD[0] = 64'hA3;
      expA[1] = 5'd4; expD[1] = 64'hA4;
      expA[2] = 5'd6; expD[2] = 64'hA5;
      for (int i = 1; i <= 4; i++) push(5'(i), 64'hA0 + 64'(i));
      nCmp++; if (Count !== 5'd4 || InReady !== 1'b0) begin nErr++; $display("FAIL full_state got %0d/%b want 4/0", Count, InReady); end
      push(5'd6, 64'hA5);
      nCmp++; if (Count !== 5'd4) begin nErr++; $display("FAIL full_ignore got %0d want 4", Count); end
      nCmp++; if (RW !== 5'd1 || BusW !== 64'hA1) begin nErr++; $display("FAIL full_head got %0d/%h want 1/a1", RW, BusW); end
      // Full: drain only this cycle.
      InValid = 1'b1; InRW = 5'd6; InData = 64'hA5; RfGrant = 1'b1; #1;
      nCmp++; if (InReady !== 1'b0 || RegWr !== 1'b1 || RW !== 5'd1) begin nErr++; $display("FAIL full_pop got %b/%b/%0d want 0/1/1", InReady, RegWr, RW); end
      @(posedge Clk); #1;
      nCmp++; if (Count !== 5'd3 || InReady !== 1'b1) begin nErr++; $display("FAIL full_after_pop got %0d/%b want 3/1", Count, InReady); end
      nCmp++; if (RW !== 5'd2 || BusW !== 64'hA2) begin nErr++; $display("FAIL full_head2 got %0d/%h want 2/a2", RW, BusW); end
      // Accept and drain together: occupancy holds.
      @(posedge Clk); #1;
      InValid = 1'b0;
      nCmp++; if (Count !== 5'd3) begin nErr++; $display("FAIL acc_drain_count got %0d want 3", Count); end
      RB = 5'd6; #1;
      nCmp++; if (HitB !== 1'b1 || FwdB !== 64'hA5) begin nErr++; $display("FAIL wrap_fwd got %b/%h want 1/a5", HitB, FwdB); end
      for (int i = 0; i < 3; i++) begin
         nCmp++; if (RegWr !== 1'b1 || RW !== expA[i] || BusW !== expD[i]) begin
            nErr++; $display("FAIL wrap_order_%0d got %b/%0d/%h want 1/%0d/%h", i, RegWr, RW, BusW, expA[i], expD[i]);
         end
         @(posedge Clk); #1;
      end
      nCmp++; if (Empty !== 1'b1 || Count !== 5'd0) begin nErr++; $display("FAIL wrap_end got %b/%0d want 1/0", Empty, Count); end
      RfGrant = 1'b0;
   endtask

   task automatic test_xzr;
      push(5'd31, 64'hFF);
      RA = 5'd31; #1;
      nCmp++; if (Count !== 5'd0 || Empty !== 1'b1) begin nErr++; $display("FAIL xzr_count got %0d/%b want 0/1", Count, Empty); end
      nCmp++; if (HitA !== 1'b0 || FwdA !== 64'd0) begin nErr++; $display("FAIL xzr_fwd got %b/%h want 0/0", HitA, FwdA); end
      RfGrant = 1'b1; #1;
      nCmp++; if (RegWr !== 1'b0) begin nErr++; $display("FAIL xzr_regwr got %b want 0", RegWr); end
      RfGrant = 1'b0;
      push(5'd7, 64'h77);
      push(5'd31, 64'hFF);
      RB = 5'd7; #1;
      nCmp++; if (Count !== 5'd1) begin nErr++; $display("FAIL xzr_mixed_count got %0d want 1", Count); end
      nCmp++; if (HitA !== 1'b0 || HitB !== 1'b1 || FwdB !== 64'h77) begin nErr++; $display("FAIL xzr_mixed_hit got %b/%b/%h want 0/1/77", HitA, HitB, FwdB); end
      RfGrant = 1'b1; #1;
      nCmp++; if (RegWr !== 1'b1 || RW !== 5'd7 || BusW !== 64'h77) begin nErr++; $display("FAIL xzr_drain got %b/%0d/%h want 1/7/77", RegWr, RW, BusW); end
      @(posedge Clk); #1;
      nCmp++; if (RegWr !== 1'b0 || Empty !== 1'b1) begin nErr++; $display("FAIL xzr_after got %b/%b want 0/1", RegWr, Empty); end
      RfGrant = 1'b0;
   endtask

   task automatic test_reset_mid;
      push(5'd8, 64'h80);
      push(5'd9, 64'h90);
      push(5'd10, 64'hA0);
      RA = 5'd9; RB = 5'd8; RfGrant = 1'b1; #1;
      nCmp++; if (Count !== 5'd3 || RegWr !== 1'b1 || HitA !== 1'b1) begin nErr++; $display("FAIL pre_rst got %0d/%b/%b want 3/1/1", Count, RegWr, HitA); end
      Reset = 1'b1; #1;
      nCmp++; if (RegWr !== 1'b0 || Count !== 5'd0 || Empty !== 1'b1) begin nErr++; $display("FAIL mid_rst got %b/%0d/%b want 0/0/1", RegWr, Count, Empty); end
      nCmp++; if (HitA !== 1'b0 || HitB !== 1'b0 || FwdA !== 64'd0) begin nErr++; $display("FAIL mid_rst_hit got %b/%b/%h want 0/0/0", HitA, HitB, FwdA); end
      nCmp++; if (RW !== 5'd0 || BusW !== 64'd0) begin nErr++; $display("FAIL mid_rst_port got %0d/%h want 0/0", RW, BusW); end
      #1; Reset = 1'b0; RfGrant = 1'b0;
      @(posedge Clk); #1;
      push(5'd12, 64'hC0);
      nCmp++; if (Count !== 5'd1 || RW !== 5'd12 || BusW !== 64'hC0) begin nErr++; $display("FAIL post_rst got %0d/%0d/%h want 1/12/c0", Count, RW, BusW); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_drain();
      test_full();
      test_xzr();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
